// File: rtl/word_sum_pkg.sv
// Shared types and constants for the word-sum collector and its helper stage.
// Holds width defaults, a constant clog2, and the two state encodings.
package word_sum_pkg;

    localparam int SUM_WIDTH_DEF = 10;
    localparam int BATCH_DEF     = 4;

    // Bits needed to index 'value' items; evaluated at elaboration time only.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef enum logic {COLLECT, DONE} coll_state_e;
    typedef enum logic {EMPTY, FULL}   res_state_e;

endpackage

// File: rtl/word_sum_collector_rise_detect.sv
// Registers a level and emits a one-cycle pulse on its rising edge.
// RESET_VAL=1 suppresses a pulse for a level already high when reset releases.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            level_q <= RESET_VAL;
        end else begin
            level_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/word_sum_collector.sv
// Collects BATCH upstream sums and reports total/max/min on a valid/ready port.
// The result register is separate from the accumulator so collection never stalls.
module word_sum_collector
    import word_sum_pkg::*;
#(
    parameter int  SUM_WIDTH = SUM_WIDTH_DEF,
    parameter int  BATCH     = BATCH_DEF,
    localparam int ACC_WIDTH = SUM_WIDTH + clog2(BATCH),
    localparam int CNT_WIDTH = clog2(BATCH) + 1
) (
    input  logic                 clk,
    input  logic                 async_reset,
    input  logic                 in_valid,
    input  logic [SUM_WIDTH-1:0] in_sum,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_total,
    output logic [SUM_WIDTH-1:0] out_max,
    output logic [SUM_WIDTH-1:0] out_min,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] fill_level
);

    logic                 capture;
    coll_state_e          state_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [SUM_WIDTH-1:0] max_q;
    logic [SUM_WIDTH-1:0] min_q;

    res_state_e           res_q;
    logic [ACC_WIDTH-1:0] total_q;
    logic [SUM_WIDTH-1:0] res_max_q;
    logic [SUM_WIDTH-1:0] res_min_q;
    logic                 overrun_q;

    // clear deliberately does not touch the edge detector: it keeps tracking in_valid.
    rise_detect #(
        .RESET_VAL(1'b1)
    ) u_rise (
        .clk     (clk),
        .rst_n_i (async_reset),
        .level_i (in_valid),
        .pulse_o (capture)
    );

    always_ff @(posedge clk) begin
        if (!async_reset || clear) begin
            state_q <= COLLECT;
            count_q <= '0;
            acc_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (capture) begin
                        acc_q <= acc_q + ACC_WIDTH'(in_sum);
                        if (count_q == '0) begin
                            max_q <= in_sum;
                            min_q <= in_sum;
                        end else begin
                            if (in_sum > max_q) max_q <= in_sum;
                            if (in_sum < min_q) min_q <= in_sum;
                        end
                        count_q <= count_q + CNT_WIDTH'(1);
                        if (count_q == CNT_WIDTH'(BATCH - 1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= COLLECT;
                    count_q <= '0;
                    acc_q   <= '0;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    // A held result is only replaced if it is being transferred in the same cycle.
    always_ff @(posedge clk) begin
        if (!async_reset || clear) begin
            res_q     <= EMPTY;
            total_q   <= '0;
            res_max_q <= '0;
            res_min_q <= '0;
            overrun_q <= 1'b0;
        end else if (state_q == DONE) begin
            if (res_q == EMPTY || out_ready) begin
                res_q     <= FULL;
                total_q   <= acc_q;
                res_max_q <= max_q;
                res_min_q <= min_q;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (res_q == FULL && out_ready) begin
            res_q <= EMPTY;
        end
    end

    assign out_valid  = (res_q == FULL);
    assign out_total  = total_q;
    assign out_max    = res_max_q;
    assign out_min    = res_min_q;
    assign overrun    = overrun_q;
    assign fill_level = count_q;

endmodule

// File: tb/tb_word_sum_collector.sv
// Directed bench for word_sum_collector with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_word_sum_collector;

    logic        clk;
    logic        async_reset;
    logic        in_valid;
    logic [9:0]  in_sum;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_total;
    logic [9:0]  out_max;
    logic [9:0]  out_min;
    logic        overrun;
    logic [2:0]  fill_level;

    int checks = 0;
    int errors = 0;

    word_sum_collector dut (
        .clk         (clk),
        .async_reset (async_reset),
        .in_valid    (in_valid),
        .in_sum      (in_sum),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_total   (out_total),
        .out_max     (out_max),
        .out_min     (out_min),
        .overrun     (overrun),
        .fill_level  (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One in_valid assertion: 3 cycles high, 2 cycles low.
    task automatic send(input logic [9:0] s);
        in_valid = 1'b1;
        in_sum   = s;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (2) tick();
    endtask

    // Final sample of a batch with out_ready=1, checking result timing.
    task automatic last_sample(input string tag, input logic [9:0] s, input logic [11:0] tot,
                               input logic [9:0] mx, input logic [9:0] mn);
        in_valid = 1'b1;
        in_sum   = s;
        tick();
        check({tag, "_done_fill"}, 32'(fill_level), 32'd4);
        check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_total"}, 32'(out_total), 32'(tot));
        check({tag, "_max"}, 32'(out_max), 32'(mx));
        check({tag, "_min"}, 32'(out_min), 32'(mn));
        check({tag, "_fill0"}, 32'(fill_level), 32'd0);
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        async_reset = 1'b0;
        in_valid    = 1'b0;
        in_sum      = '0;
        clear       = 1'b0;
        out_ready   = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_total", 32'(out_total), 32'd0);
        check("rst_max", 32'(out_max), 32'd0);
        check("rst_min", 32'(out_min), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        async_reset = 1'b1;
        tick();

        // Single batch of equal samples.
        send(10'd8);
        send(10'd8);
        send(10'd8);
        check("b1_fill3", 32'(fill_level), 32'd3);
        last_sample("b1", 10'd8, 12'h020, 10'd8, 10'd8);

        // Mixed values, then full scale.
        send(10'h3FF);
        send(10'h000);
        send(10'h005);
        last_sample("mix", 10'h200, 12'h604, 10'h3FF, 10'h000);
        send(10'h3FF);
        send(10'h3FF);
        send(10'h3FF);
        last_sample("full", 10'h3FF, 12'hFFC, 10'h3FF, 10'h3FF);

        // Backpressure: batch 1 held, batch 2 dropped.
        out_ready = 1'b0;
        send(10'd1);
        send(10'd2);
        send(10'd3);
        send(10'd4);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_total", 32'(out_total), 32'd10);
        check("bp_overrun0", 32'(overrun), 32'd0);
        send(10'd10);
        send(10'd20);
        send(10'd30);
        send(10'd40);
        check("bp_held_valid", 32'(out_valid), 32'd1);
        check("bp_held_total", 32'(out_total), 32'd10);
        check("bp_held_max", 32'(out_max), 32'd4);
        check("bp_held_min", 32'(out_min), 32'd1);
        check("bp_overrun1", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_xfer_valid", 32'(out_valid), 32'd0);
        check("bp_overrun_sticky", 32'(overrun), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_overrun", 32'(overrun), 32'd0);
        check("clr_valid", 32'(out_valid), 32'd0);

        // Transfer of held batch and load of new batch in the same cycle.
        out_ready = 1'b0;
        send(10'd5);
        send(10'd5);
        send(10'd5);
        send(10'd5);
        check("sim_b1_total", 32'(out_total), 32'd20);
        send(10'd6);
        send(10'd7);
        send(10'd8);
        in_valid = 1'b1;
        in_sum   = 10'd9;
        tick();
        out_ready = 1'b1;
        tick();
        check("sim_valid", 32'(out_valid), 32'd1);
        check("sim_total", 32'(out_total), 32'd30);
        check("sim_max", 32'(out_max), 32'd9);
        check("sim_min", 32'(out_min), 32'd6);
        check("sim_overrun", 32'(overrun), 32'd0);
        tick();
        check("sim_valid_drop", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        repeat (2) tick();

        // Level-held valid captures once.
        in_valid = 1'b1;
        in_sum   = 10'd3;
        repeat (20) tick();
        check("level_fill1", 32'(fill_level), 32'd1);
        in_valid = 1'b0;
        tick();

        // in_valid high across reset release is ignored.
        in_valid    = 1'b1;
        async_reset = 1'b0;
        tick();
        tick();
        async_reset = 1'b1;
        repeat (3) tick();
        check("rst_level_fill0", 32'(fill_level), 32'd0);
        in_valid = 1'b0;
        repeat (2) tick();

        // Clear mid-batch discards partial samples.
        send(10'd9);
        send(10'd9);
        check("pre_clear_fill", 32'(fill_level), 32'd2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("post_clear_fill", 32'(fill_level), 32'd0);
        send(10'd1);
        send(10'd1);
        send(10'd1);
        last_sample("clr", 10'd1, 12'd4, 10'd1, 10'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
